// File: rtl/frame_buf_writer.sv
// Frame-buffer write side: takes a valid/ready RGB pixel stream and writes one
// frame into the BRAM write port. Each frame starts in vertical blank, and the
// write can be mirrored horizontally and/or vertically.
module frame_buf_writer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              vblank,
    input  logic              hmir,
    input  logic              vmir,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_VB, WRITE, DONE} state_t;

    state_t            state, state_nx;
    logic [X_W-1:0]    x, x_nx, wx, xa;
    logic [Y_W-1:0]    y, y_nx, wy, ya;
    logic              synced, synced_nx;
    logic              hmir_l, vmir_l;
    logic              do_write, resync_err;
    logic [ADDR_W-1:0] wr_addr;

    assign in_ready   = (state == WRITE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // An in_sof beat always lands at (0,0), whatever the counters hold.
    assign wx = in_sof ? '0 : x;
    assign wy = in_sof ? '0 : y;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        x_nx       = x;
        y_nx       = y;
        synced_nx  = synced;
        do_write   = 1'b0;
        resync_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = WAIT_VB;
            end
            WAIT_VB: begin
                if (vblank) begin
                    state_nx  = WRITE;
                    x_nx      = '0;
                    y_nx      = '0;
                    synced_nx = 1'b0;
                end
            end
            WRITE: begin
                // Beats that arrive before the first in_sof are accepted and dropped.
                if (in_valid && (in_sof || synced)) begin
                    do_write   = 1'b1;
                    synced_nx  = 1'b1;
                    resync_err = in_sof && synced && ((x != '0) || (y != '0));
                    if (wx == X_W'(H_RES - 1)) begin
                        x_nx = '0;
                        y_nx = wy + 1'b1;
                        if (wy == Y_W'(V_RES - 1)) state_nx = DONE;
                    end else begin
                        x_nx = wx + 1'b1;
                        y_nx = wy;
                    end
                end
            end
            DONE: begin
                state_nx = cont ? WAIT_VB : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        xa      = hmir_l ? (X_W'(H_RES - 1) - wx) : wx;
        ya      = vmir_l ? (Y_W'(V_RES - 1) - wy) : wy;
        wr_addr = ADDR_W'(ya) * ADDR_W'(H_RES) + ADDR_W'(xa);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            synced  <= 1'b0;
            hmir_l  <= 1'b0;
            vmir_l  <= 1'b0;
            wea     <= 1'b0;
            sof_err <= 1'b0;
            // NOTE: the write-port datapath is cleared too, so the BRAM port
            // shows known values straight out of reset.
            addra   <= '0;
            dina    <= '0;
        end else begin
            state   <= state_nx;
            x       <= x_nx;
            y       <= y_nx;
            synced  <= synced_nx;
            wea     <= do_write;
            sof_err <= resync_err;
            if (state == WAIT_VB && vblank) begin
                hmir_l <= hmir;
                vmir_l <= vmir;
            end
            if (do_write) begin
                addra <= wr_addr;
                dina  <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_buf_writer.sv
// Self-checking bench for frame_buf_writer: a full-size instance covers the
// address corners, and a small-frame instance covers whole-frame sequences.
module tb_frame_buf_writer;

    localparam int BH = 320;
    localparam int BV = 240;
    localparam int SH = 20;
    localparam int SV = 12;
    localparam int AW = 17;
    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, cont, vblank, hmir, vmir, in_valid, in_sof;
    logic [DW-1:0] in_data;
    logic          big;

    logic          b_in_ready, b_wea, b_busy, b_frame_done, b_sof_err;
    logic [AW-1:0] b_addra;
    logic [DW-1:0] b_dina;
    logic          s_in_ready, s_wea, s_busy, s_frame_done, s_sof_err;
    logic [AW-1:0] s_addra;
    logic [DW-1:0] s_dina;

    logic          o_in_ready, o_wea, o_busy, o_frame_done, o_sof_err;
    logic [AW-1:0] o_addra;
    logic [DW-1:0] o_dina;

    frame_buf_writer #(.H_RES(BH), .V_RES(BV), .ADDR_W(AW), .DATA_W(DW)) dut_big (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .vblank(vblank),
        .hmir(hmir), .vmir(vmir), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(b_in_ready), .wea(b_wea), .addra(b_addra),
        .dina(b_dina), .busy(b_busy), .frame_done(b_frame_done), .sof_err(b_sof_err)
    );

    frame_buf_writer #(.H_RES(SH), .V_RES(SV), .ADDR_W(AW), .DATA_W(DW)) dut_small (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .vblank(vblank),
        .hmir(hmir), .vmir(vmir), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(s_in_ready), .wea(s_wea), .addra(s_addra),
        .dina(s_dina), .busy(s_busy), .frame_done(s_frame_done), .sof_err(s_sof_err)
    );

    assign o_in_ready   = big ? b_in_ready   : s_in_ready;
    assign o_wea        = big ? b_wea        : s_wea;
    assign o_addra      = big ? b_addra      : s_addra;
    assign o_dina       = big ? b_dina       : s_dina;
    assign o_busy       = big ? b_busy       : s_busy;
    assign o_frame_done = big ? b_frame_done : s_frame_done;
    assign o_sof_err    = big ? b_sof_err    : s_sof_err;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int total = 0;
    int bad   = 0;

    // Monitor: everything the selected DUT writes, plus pulse counters.
    wr_t     got[$];
    int      fd_cnt, se_cnt, rdy_cnt;
    logic    fd_wea;
    logic [AW-1:0] fd_addr;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (o_wea) got.push_back('{a: o_addra, d: o_dina});
            if (o_frame_done) begin
                fd_cnt++;
                fd_wea  = o_wea;
                fd_addr = o_addra;
            end
            if (o_sof_err) se_cnt++;
            if (o_in_ready) rdy_cnt++;
        end
    end

    // Reference model: pixel index k since the last sync gives (k%H, k/H).
    wr_t exp_q[$];
    int  mh, mv, m_k, m_serr;
    bit  m_sync, m_hm, m_vm;

    function automatic void model_beat(input logic [DW-1:0] d, input bit s);
        int xa, ya;
        if (s) begin
            if (m_sync && m_k != 0) m_serr++;
            m_k    = 0;
            m_sync = 1'b1;
        end else if (!m_sync) begin
            return;
        end
        xa = m_k % mh;
        ya = m_k / mh;
        if (m_hm) xa = mh - 1 - xa;
        if (m_vm) ya = mv - 1 - ya;
        exp_q.push_back('{a: AW'(ya * mh + xa), d: d});
        m_k++;
        if (m_k == mh * mv) begin
            m_k    = 0;
            m_sync = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic select(input bit use_big);
        big = use_big;
        mh  = use_big ? BH : SH;
        mv  = use_big ? BV : SV;
    endtask

    task automatic clear_scoreboard();
        got.delete();
        exp_q.delete();
        fd_cnt  = 0;
        se_cnt  = 0;
        rdy_cnt = 0;
        m_serr  = 0;
        m_k     = 0;
        m_sync  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        start    = 1'b0;
        cont     = 1'b0;
        vblank   = 1'b0;
        hmir     = 1'b0;
        vmir     = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        clear_scoreboard();
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Optional start pulse, 5 cycles out of blank, then vblank until WRITE.
    task automatic arm(input bit do_start, input bit hm, input bit vm);
        hmir   = hm;
        vmir   = vm;
        vblank = 1'b0;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (5) @(negedge clk);
        vblank = 1'b1;
        for (int t = 0; t < 10 && !o_in_ready; t++) @(negedge clk);
        check("arm_in_ready", o_in_ready, 1);
        m_hm   = hm;
        m_vm   = vm;
        m_k    = 0;
        m_sync = 1'b0;
    endtask

    // Present one beat at a negedge; it is taken at the next posedge with in_ready.
    task automatic send(input logic [DW-1:0] d, input bit s);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        t = 0;
        while (!o_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("beat_in_ready", o_in_ready, 1);
        if (o_in_ready) model_beat(d, s);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic score(input string tag);
        check({tag, "_write_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_write"}, got[i], exp_q[i]);
    endtask

    typedef struct {
        bit hm;
        bit vm;
        int idx;
        int exp_addr;
    } mir_vec_t;

    mir_vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0,   0,     0};
        vecs[1] = '{0, 0, 319,   319};
        vecs[2] = '{0, 0, 320,   320};
        vecs[3] = '{1, 1,   0, 76799};
        vecs[4] = '{1, 1,   1, 76798};
        vecs[5] = '{1, 1, 320, 76479};
        vecs[6] = '{1, 0,   0,   319};
        vecs[7] = '{0, 1,   0, 76480};
        vecs[8] = '{1, 0, 320,   639};

        // Reset state on both instances, then idle with start low.
        select(1);
        rst = 1'b0; start = 1'b0; cont = 1'b0; vblank = 1'b0; hmir = 1'b0;
        vmir = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        clear_scoreboard();
        @(negedge clk);
        check("reset_outputs_big",
              {b_wea, b_addra, b_dina, b_in_ready, b_busy, b_frame_done, b_sof_err}, 0);
        check("reset_outputs_small",
              {s_wea, s_addra, s_dina, s_in_ready, s_busy, s_frame_done, s_sof_err}, 0);
        rst = 1'b1;
        vblank = 1'b1;
        in_valid = 1'b1;
        in_sof = 1'b1;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        in_sof = 1'b0;
        check("idle_in_ready_cycles", rdy_cnt, 0);
        check("idle_writes", got.size(), 0);
        check("idle_busy", o_busy, 0);

        // Address corners on the full-size frame.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            arm(1, vecs[i].hm, vecs[i].vm);
            for (int b = 0; b <= vecs[i].idx; b++) send(DW'($urandom), b == 0);
            repeat (2) @(negedge clk);
            check("mirror_write_count", got.size(), vecs[i].idx + 1);
            if (got.size() > vecs[i].idx)
                check("mirror_addr", got[vecs[i].idx].a, vecs[i].exp_addr);
            score("mirror");
        end

        // Basic full frame, no mirroring, back-to-back beats.
        select(0);
        do_reset();
        arm(1, 0, 0);
        for (int b = 0; b < SH * SV; b++) send(DW'($urandom), b == 0);
        repeat (3) @(negedge clk);
        check("basic_frame_done_cnt", fd_cnt, 1);
        check("basic_frame_done_wea", fd_wea, 1);
        check("basic_frame_done_addr", fd_addr, SH * SV - 1);
        check("basic_busy_after", o_busy, 0);
        check("basic_sof_err_cnt", se_cnt, 0);
        score("basic");

        // Pre-sync drop, then a mid-frame resync.
        do_reset();
        arm(1, 0, 0);
        for (int b = 0; b < 3; b++) send(DW'($urandom), 1'b0);
        for (int b = 0; b < 100 + SH * SV; b++) send(DW'($urandom), b == 0 || b == 100);
        repeat (3) @(negedge clk);
        check("resync_sof_err_cnt", se_cnt, m_serr);
        check("resync_sof_err_seen", se_cnt, 1);
        if (got.size() > 0) check("resync_first_addr", got[0].a, 0);
        check("resync_frame_done_cnt", fd_cnt, 1);
        score("resync");

        // Random stalls and mirroring, vblank drop and ignored start mid-frame.
        for (int f = 0; f < 3; f++) begin
            bit hm, vm;
            hm = 1'($urandom);
            vm = 1'($urandom);
            do_reset();
            arm(1, hm, vm);
            hmir = ~hm;
            vmir = ~vm;
            for (int b = 0; b < SH * SV; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (b == 50) vblank = 1'b0;
                if (b == 80) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send(DW'($urandom), b == 0);
            end
            repeat (3) @(negedge clk);
            check("stall_frame_done_cnt", fd_cnt, 1);
            check("stall_busy_after", o_busy, 0);
            score("stall");
        end

        // Continuous mode, then reset in the middle of the second frame.
        do_reset();
        cont = 1'b1;
        arm(1, 0, 0);
        for (int b = 0; b < SH * SV; b++) begin
            if (b == 10) vblank = 1'b0;
            send(DW'($urandom), b == 0);
        end
        repeat (3) @(negedge clk);
        check("cont_frame_done_cnt", fd_cnt, 1);
        check("cont_busy_wait_vb", o_busy, 1);
        repeat (5) @(negedge clk);
        check("cont_ready_wait_vb", o_in_ready, 0);
        score("cont_f1");
        arm(0, 0, 0);
        for (int b = 0; b < 100; b++) send(DW'($urandom), b == 0);
        check("cont_pending_wea", o_wea, 1);
        rst = 1'b0;
        #1;
        check("midreset_outputs",
              {o_wea, o_addra, o_dina, o_in_ready, o_busy, o_frame_done, o_sof_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset_frame_done_cnt", fd_cnt, 1);
        check("midreset_busy_after", o_busy, 0);
        check("midreset_ready_after", o_in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
